instr_sequencer: RTL and testbench

Fetch/issue sequencer for the simple datapath. It owns the program counter and instruction register, and reads instruction words from memory over a ready handshake. It hands each instruction to the datapath controller through its `start`/`waiting` handshake and counts retired instructions. It sits between instruction memory and the datapath controller. The decoder consumes `ir`.

---
 rtl/instr_sequencer.sv | 130 +++++++++++++
 tb/tb_instr_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/issue sequencer for the simple datapath.
// Owns the program counter and instruction register. Fetches instruction
// words over a ready handshake and hands each one to the datapath controller
// through its start/waiting handshake. Counts retired instructions and parks
// permanently in HALT when it fetches the HALT opcode.
module instr_sequencer #(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ready,
    input  logic              exec_waiting,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic [15:0]       ir,
    output logic [ADDR_W-1:0] pc,
    output logic              exec_start,
    output logic              halted,
    output logic [15:0]       retired
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        EXEC  = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [2:0]  HALT_OPCODE = 3'b111;
    localparam logic [15:0] RETIRED_MAX = 16'hFFFF;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       ir_q;
    logic [15:0]       retired_q;
    logic              fetch_accept;
    logic              exec_done;

    // Next-state decode plus Moore outputs taken straight from the state register.
    always_comb begin
        state_next   = state;
        fetch_accept = 1'b0;
        exec_done    = 1'b0;
        mem_rd       = 1'b0;
        exec_start   = 1'b0;
        halted       = 1'b0;

        case (state)
            IDLE: begin
                if (run) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    fetch_accept = 1'b1;
                    if (mem_rdata[15:13] == HALT_OPCODE) begin
                        state_next = HALT;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                exec_start = 1'b1;
                if (!exec_waiting) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (exec_waiting) begin
                    exec_done = 1'b1;
                    if (run) begin
                        state_next = FETCH;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            HALT: begin
                halted     = 1'b1;
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset forces IDLE so all handshake outputs drop at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the instruction and advance pc together when memory delivers a word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            ir_q <= 16'h0000;
        end else if (fetch_accept) begin
            pc_q <= pc_q + ADDR_W'(1);
            ir_q <= mem_rdata;
        end
    end

    // Count completed instructions, holding at the maximum instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= 16'h0000;
        end else if (exec_done && (retired_q != RETIRED_MAX)) begin
            retired_q <= retired_q + 16'd1;
        end
    end

    assign pc       = pc_q;
    assign mem_addr = pc_q;
    assign ir       = ir_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scenario tasks for instr_sequencer with a scoreboard of
// expected (ir, pc) pairs pushed at fetch acceptance and checked at issue.
module tb_instr_sequencer;

    localparam int unsigned ADDR_W   = 8;
    localparam logic [7:0]  RESET_PC = 8'h10;

    typedef struct packed {
        logic [15:0] ir;
        logic [7:0]  pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        exec_waiting;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [15:0] ir;
    logic [7:0]  pc;
    logic        exec_start;
    logic        halted;
    logic [15:0] retired;

    int          total = 0;
    int          bad   = 0;
    exp_t        sb_q[$];
    logic [7:0]  exp_pc;
    logic [15:0] exp_retired;
    bit          start_seen = 1'b0;

    instr_sequencer #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .exec_waiting (exec_waiting),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .ir           (ir),
        .pc           (pc),
        .exec_start   (exec_start),
        .halted       (halted),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    // Scoreboard checker: each new issue must present the next expected ir/pc.
    always @(negedge clk) begin
        exp_t e;
        if (exec_start === 1'b1 && !start_seen) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL sb_unexpected_issue: got ir=%h pc=%h want no issue", ir, pc);
            end else begin
                e = sb_q.pop_front();
                if (ir !== e.ir || pc !== e.pc) begin
                    bad++;
                    $display("[TB] FAIL sb_issue: got ir=%h pc=%h want ir=%h pc=%h", ir, pc, e.ir, e.pc);
                end
            end
        end
        start_seen = (exec_start === 1'b1);
    end

    // Drives one complete instruction: fetch with wait states, then a
    // controller that keeps waiting low for exec_len sampled cycles.
    task automatic do_instr(input logic [15:0] data, input int waits, input int exec_len,
                            input bit drop_run, output int rd_cyc, output int start_cyc,
                            output bit ok, output bit addr_stable);
        int         guard;
        logic [7:0] pc0;
        rd_cyc      = 0;
        start_cyc   = 0;
        ok          = 1'b1;
        addr_stable = 1'b1;
        guard       = 0;
        while (mem_rd !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (mem_rd !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        pc0 = exp_pc;
        for (int w = 0; w <= waits; w++) begin
            mem_ready = (w == waits);
            mem_rdata = (w == waits) ? data : 16'($urandom);
            if (w == waits) begin
                sb_q.push_back(exp_t'{ir: data, pc: pc0 + 8'd1});
                exp_pc = pc0 + 8'd1;
            end
            if (mem_rd === 1'b1) rd_cyc++;
            if (exec_start === 1'b1) start_cyc++;
            if (pc !== pc0 || mem_addr !== pc0) addr_stable = 1'b0;
            @(negedge clk);
        end
        mem_ready    = 1'b0;
        mem_rdata    = 16'($urandom);
        exec_waiting = 1'b0;
        for (int c = 0; c < exec_len; c++) begin
            if (mem_rd === 1'b1) rd_cyc++;
            if (exec_start === 1'b1) start_cyc++;
            @(negedge clk);
            if (c == 0 && drop_run) run = 1'b0;
        end
        exec_waiting = 1'b1;
        if (mem_rd === 1'b1) rd_cyc++;
        if (exec_start === 1'b1) start_cyc++;
        @(negedge clk);
        if (exp_retired != 16'hFFFF) exp_retired = exp_retired + 16'd1;
    endtask

    // Reset asserted mid-EXEC must clear everything without a clock edge.
    task automatic test_reset();
        int rd, st, rd_cnt, guard;
        bit ok, stab;
        run = 1'b1;
        do_instr(16'h1111, 0, 1, 1'b0, rd, st, ok, stab);
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL reset_pre_fetch_timeout: got 0 want 1"); end
        guard = 0;
        while (mem_rd !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        mem_ready = 1'b1;
        mem_rdata = 16'h2222;
        sb_q.push_back(exp_t'{ir: 16'h2222, pc: exp_pc + 8'd1});
        exp_pc = exp_pc + 8'd1;
        @(negedge clk);
        mem_ready    = 1'b0;
        mem_rdata    = 16'h0000;
        exec_waiting = 1'b0;
        @(negedge clk);
        total++;
        if (retired !== 16'd1) begin bad++; $display("[TB] FAIL reset_pre_retired: got %h want 0001", retired); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (mem_rd !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_rd: got %b want 0", mem_rd); end
        total++;
        if (exec_start !== 1'b0) begin bad++; $display("[TB] FAIL reset_exec_start: got %b want 0", exec_start); end
        total++;
        if (pc !== RESET_PC) begin bad++; $display("[TB] FAIL reset_pc: got %h want %h", pc, RESET_PC); end
        total++;
        if (ir !== 16'h0000) begin bad++; $display("[TB] FAIL reset_ir: got %h want 0000", ir); end
        total++;
        if (retired !== 16'h0000) begin bad++; $display("[TB] FAIL reset_retired: got %h want 0000", retired); end
        total++;
        if (halted !== 1'b0) begin bad++; $display("[TB] FAIL reset_halted: got %b want 0", halted); end
        exec_waiting = 1'b1;
        run          = 1'b0;
        @(negedge clk);
        rst_n       = 1'b1;
        exp_pc      = RESET_PC;
        exp_retired = 16'h0000;
        rd_cnt      = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_rd === 1'b1) rd_cnt++;
        end
        total++;
        if (rd_cnt != 0) begin bad++; $display("[TB] FAIL reset_idle_hold: got %0d mem_rd cycles want 0", rd_cnt); end
    endtask

    // Zero-wait memory: one-cycle fetch, one-cycle issue, immediate refetch.
    task automatic test_zero_wait();
        int rd, st;
        bit ok, stab;
        run = 1'b1;
        do_instr(16'hD123, 0, 3, 1'b0, rd, st, ok, stab);
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL zw_timeout: got 0 want 1"); end
        total++;
        if (rd != 1) begin bad++; $display("[TB] FAIL zw_mem_rd_cycles: got %0d want 1", rd); end
        total++;
        if (st != 1) begin bad++; $display("[TB] FAIL zw_start_cycles: got %0d want 1", st); end
        total++;
        if (ir !== 16'hD123) begin bad++; $display("[TB] FAIL zw_ir: got %h want D123", ir); end
        total++;
        if (pc !== 8'h11) begin bad++; $display("[TB] FAIL zw_pc: got %h want 11", pc); end
        total++;
        if (retired !== 16'd1) begin bad++; $display("[TB] FAIL zw_retired: got %h want 0001", retired); end
        total++;
        if (mem_rd !== 1'b1) begin bad++; $display("[TB] FAIL zw_refetch: got %b want 1", mem_rd); end
    endtask

    // Memory wait states hold the request and the address stable.
    task automatic test_wait_states();
        int rd, st;
        bit ok, stab;
        do_instr(16'h4A5C, 3, 2, 1'b0, rd, st, ok, stab);
        total++;
        if (rd != 4) begin bad++; $display("[TB] FAIL ws_mem_rd_cycles: got %0d want 4", rd); end
        total++;
        if (!stab) begin bad++; $display("[TB] FAIL ws_addr_stable: got 0 want 1"); end
        total++;
        if (pc !== 8'h12) begin bad++; $display("[TB] FAIL ws_pc: got %h want 12", pc); end
        total++;
        if (st != 1) begin bad++; $display("[TB] FAIL ws_start_cycles: got %0d want 1", st); end
        total++;
        if (retired !== exp_retired) begin bad++; $display("[TB] FAIL ws_retired: got %h want %h", retired, exp_retired); end
    endtask

    // Dropping run mid-EXEC finishes the instruction then parks in IDLE.
    task automatic test_run_drop();
        int rd, st, rd_cnt, guard;
        bit ok, stab;
        do_instr(16'h0777, 0, 2, 1'b1, rd, st, ok, stab);
        total++;
        if (retired !== exp_retired) begin bad++; $display("[TB] FAIL rd_retired: got %h want %h", retired, exp_retired); end
        rd_cnt = 0;
        repeat (5) begin
            if (mem_rd === 1'b1) rd_cnt++;
            @(negedge clk);
        end
        total++;
        if (rd_cnt != 0) begin bad++; $display("[TB] FAIL rd_parked: got %0d mem_rd cycles want 0", rd_cnt); end
        total++;
        if (pc !== exp_pc) begin bad++; $display("[TB] FAIL rd_pc_hold: got %h want %h", pc, exp_pc); end
        run   = 1'b1;
        guard = 0;
        while (mem_rd !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        total++;
        if (mem_rd !== 1'b1 || mem_addr !== exp_pc) begin
            bad++;
            $display("[TB] FAIL rd_restart: got rd=%b addr=%h want rd=1 addr=%h", mem_rd, mem_addr, exp_pc);
        end
        do_instr(16'h1234, 1, 1, 1'b0, rd, st, ok, stab);
    endtask

    // Back-to-back instructions up to pc=FF, then the fetch that wraps pc.
    task automatic test_back_to_back_wrap();
        int rd, st, n, loop_err;
        bit ok, stab;
        n        = 0;
        loop_err = 0;
        while (exp_pc != 8'hFF && n < 300) begin
            do_instr(16'($urandom) & 16'hBFFF, 0, 1, 1'b0, rd, st, ok, stab);
            if (!ok || rd != 1 || st != 1) loop_err++;
            n++;
        end
        total++;
        if (loop_err != 0) begin bad++; $display("[TB] FAIL b2b_errors: got %0d want 0", loop_err); end
        total++;
        if (pc !== 8'hFF) begin bad++; $display("[TB] FAIL b2b_pc_ff: got %h want ff", pc); end
        do_instr(16'h0ABC, 0, 1, 1'b0, rd, st, ok, stab);
        total++;
        if (pc !== 8'h00 || mem_addr !== 8'h00) begin
            bad++;
            $display("[TB] FAIL wrap_pc: got pc=%h addr=%h want 00", pc, mem_addr);
        end
        total++;
        if (retired !== exp_retired) begin bad++; $display("[TB] FAIL b2b_retired: got %h want %h", retired, exp_retired); end
    endtask

    // Retired count reaches FFFF and then holds there.
    task automatic test_saturation();
        int rd, st;
        bit ok, stab;
        force dut.retired_q = 16'hFFFE;
        #1;
        release dut.retired_q;
        exp_retired = 16'hFFFE;
        do_instr(16'h2468, 0, 1, 1'b0, rd, st, ok, stab);
        total++;
        if (retired !== 16'hFFFF) begin bad++; $display("[TB] FAIL sat_reach: got %h want ffff", retired); end
        do_instr(16'h1357, 0, 2, 1'b0, rd, st, ok, stab);
        total++;
        if (retired !== 16'hFFFF) begin bad++; $display("[TB] FAIL sat_hold: got %h want ffff", retired); end
    endtask

    // HALT opcode at pc=5: sticky halt, never issued, inputs ignored.
    task automatic test_halt();
        int          rd, st, n, guard, err_cnt;
        bit          ok, stab;
        logic [15:0] ret0;
        n = 0;
        while (exp_pc != 8'h05 && n < 20) begin
            do_instr(16'h0100, 0, 1, 1'b0, rd, st, ok, stab);
            n++;
        end
        ret0  = exp_retired;
        guard = 0;
        while (mem_rd !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        total++;
        if (mem_rd !== 1'b1 || mem_addr !== 8'h05) begin
            bad++;
            $display("[TB] FAIL halt_fetch_addr: got rd=%b addr=%h want rd=1 addr=05", mem_rd, mem_addr);
        end
        mem_ready = 1'b1;
        mem_rdata = 16'hE000;
        @(negedge clk);
        mem_ready = 1'b0;
        total++;
        if (halted !== 1'b1) begin bad++; $display("[TB] FAIL halt_flag: got %b want 1", halted); end
        total++;
        if (exec_start !== 1'b0) begin bad++; $display("[TB] FAIL halt_no_start: got %b want 0", exec_start); end
        total++;
        if (pc !== 8'h06) begin bad++; $display("[TB] FAIL halt_pc: got %h want 06", pc); end
        total++;
        if (retired !== ret0) begin bad++; $display("[TB] FAIL halt_retired: got %h want %h", retired, ret0); end
        err_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            run          = 1'($urandom);
            mem_ready    = 1'($urandom);
            mem_rdata    = 16'($urandom);
            exec_waiting = 1'($urandom);
            @(negedge clk);
            if (halted !== 1'b1 || exec_start !== 1'b0 || mem_rd !== 1'b0 ||
                pc !== 8'h06 || ir !== 16'hE000 || retired !== ret0) err_cnt++;
        end
        total++;
        if (err_cnt != 0) begin bad++; $display("[TB] FAIL halt_sticky: got %0d bad cycles want 0", err_cnt); end
    endtask

    // Bound the whole run so a stuck DUT still ends the simulation.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence.
    initial begin
        rst_n        = 1'b0;
        run          = 1'b0;
        mem_rdata    = 16'h0000;
        mem_ready    = 1'b0;
        exec_waiting = 1'b1;
        exp_pc       = RESET_PC;
        exp_retired  = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_run_drop();
        test_back_to_back_wrap();
        test_saturation();
        test_halt();
        total++;
        if (sb_q.size() != 0) begin bad++; $display("[TB] FAIL sb_leftover: got %0d want 0", sb_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
